// File: rtl/bram_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_ctrl
// Purpose  : Loads a valid/ready burst into BRAM port 0, then streams it back
//            out through a 2-entry skid FIFO that hides the 1-cycle read.
// Options  : BRAM_CTRL_REVERSE_RD_EN - read addresses N-1..0 (LIFO order)
// Revision : 1.0 - initial release
// ============================================================================
module bram_stream_ctrl #(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 8,
   parameter int MEM_SIZE = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [AWIDTH:0]   num_cnt_i,
   output logic              idle_o,
   output logic              done_o,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [DWIDTH-1:0] s_data_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DWIDTH-1:0] m_data_o,
   output logic [AWIDTH-1:0] addr_o,
   output logic              ce_o,
   output logic              we_o,
   output logic [DWIDTH-1:0] d_o,
   input  logic [DWIDTH-1:0] q_i
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_write = 2'd1;
   localparam logic [1:0] c_st_read  = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   localparam logic [AWIDTH:0] c_mem_size = (AWIDTH+1)'(MEM_SIZE);

   logic [1:0]        r_state;
   logic [AWIDTH:0]   r_n;
   logic [AWIDTH:0]   r_wr_cnt;
   logic [AWIDTH:0]   r_rd_cnt;
   logic [AWIDTH:0]   r_out_cnt;
   logic              r_pending;
   logic [DWIDTH-1:0] r_fifo [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_count;

   logic              w_wr_fire;
   logic              w_pop;
   logic [2:0]        w_occ;
   logic              w_rd_issue;
   logic [AWIDTH-1:0] w_rd_addr;
   logic [AWIDTH:0]   w_n_clamped;

   assign w_n_clamped = (num_cnt_i > c_mem_size) ? c_mem_size : num_cnt_i;

   assign w_wr_fire = (r_state == c_st_write) && s_valid_i;
   assign w_pop     = (r_count != 2'd0) && m_ready_i;

   // Words in the FIFO plus the one in flight from the BRAM; a pop this cycle
   // frees a slot so a full pipeline can still issue and keep 1 word/cycle.
   assign w_occ      = {1'b0, r_count} + {2'b00, r_pending};
   assign w_rd_issue = (r_state == c_st_read) && (r_rd_cnt < r_n) &&
                       ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));

`ifdef BRAM_CTRL_REVERSE_RD_EN
   assign w_rd_addr = AWIDTH'(r_n - r_rd_cnt - 1'b1);
`else
   assign w_rd_addr = r_rd_cnt[AWIDTH-1:0];
`endif

   assign idle_o    = (r_state == c_st_idle);
   assign done_o    = (r_state == c_st_done);
   assign s_ready_o = (r_state == c_st_write);
   assign m_valid_o = (r_count != 2'd0);
   assign m_data_o  = r_fifo[r_rptr];

   assign ce_o   = w_wr_fire | w_rd_issue;
   assign we_o   = w_wr_fire;
   assign addr_o = w_wr_fire  ? r_wr_cnt[AWIDTH-1:0] :
                   w_rd_issue ? w_rd_addr : '0;
   assign d_o    = w_wr_fire ? s_data_i : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= c_st_idle;
         r_n       <= '0;
         r_wr_cnt  <= '0;
         r_rd_cnt  <= '0;
         r_out_cnt <= '0;
         r_pending <= 1'b0;
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         r_pending <= w_rd_issue;
         if (r_pending) begin
            r_fifo[r_wptr] <= q_i;
            r_wptr         <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({r_pending, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase

         case (r_state)
            c_st_idle: begin
               if (start_i) begin
                  r_n       <= w_n_clamped;
                  r_wr_cnt  <= '0;
                  r_rd_cnt  <= '0;
                  r_out_cnt <= '0;
                  r_wptr    <= 1'b0;
                  r_rptr    <= 1'b0;
                  r_count   <= 2'd0;
                  r_state   <= (w_n_clamped == '0) ? c_st_done : c_st_write;
               end
            end
            c_st_write: begin
               if (w_wr_fire) begin
                  r_wr_cnt <= r_wr_cnt + 1'b1;
                  if (r_wr_cnt == r_n - 1'b1) begin
                     r_state <= c_st_read;
                  end
               end
            end
            c_st_read: begin
               if (w_rd_issue) begin
                  r_rd_cnt <= r_rd_cnt + 1'b1;
               end
               if (w_pop) begin
                  r_out_cnt <= r_out_cnt + 1'b1;
                  if (r_out_cnt == r_n - 1'b1) begin
                     r_state <= c_st_done;
                  end
               end
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/bram_stream_ctrl.md
Name: bram_stream_ctrl

Overview:
- Stream-side controller that drives port 0 of a true dual-port BRAM (DWIDTH/AWIDTH/MEM_SIZE style, 1-cycle registered read).
- Loads a burst of words from an upstream valid/ready stream into BRAM addresses 0..N-1.
- Then reads them back and presents them on a downstream valid/ready stream.
- Absorbs BRAM read latency with a 2-entry output skid FIFO, so throughput is full 1 word/cycle.

Parameters:
- DWIDTH, 32, data width of stream and BRAM word
- AWIDTH, 8, BRAM address width
- MEM_SIZE, 256, BRAM depth in words; also the max burst length

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start_i  in  1  start a burst; sampled only in IDLE
- num_cnt_i  in  AWIDTH+1  burst length N, latched on start
- idle_o  out  1  high in IDLE
- done_o  out  1  one-cycle pulse when the last output word is accepted
- s_valid_i  in  1  upstream word valid
- s_ready_o  out  1  upstream ready
- s_data_i  in  DWIDTH  upstream data
- m_valid_o  out  1  downstream word valid
- m_ready_i  in  1  downstream ready
- m_data_o  out  DWIDTH  downstream data
- addr_o  out  AWIDTH  BRAM port-0 address
- ce_o  out  1  BRAM chip enable
- we_o  out  1  BRAM write enable
- d_o  out  DWIDTH  BRAM write data
- q_i  in  DWIDTH  BRAM read data, valid the cycle after a read is issued

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; all counters and the FIFO are cleared.
  - idle_o=1; all other outputs 0, including ce_o, we_o, s_ready_o, m_valid_o and done_o.
  - Reset mid-burst abandons the burst. BRAM contents are not touched.
- States: IDLE -> WRITE -> READ -> DONE -> IDLE.
- IDLE:
  - On start_i=1, latch N = min(num_cnt_i, MEM_SIZE) and clear wr_cnt/rd_cnt/out_cnt.
  - N=0 goes directly to DONE; otherwise to WRITE.
  - start_i is ignored in all other states.
- WRITE:
  - s_ready_o=1 combinationally.
  - Each cycle with s_valid_i&&s_ready_o: ce_o=1, we_o=1, addr_o=wr_cnt, d_o=s_data_i (same cycle, combinational path), then wr_cnt increments.
  - On the handshake with wr_cnt==N-1: s_ready_o is 0 from the next cycle and the state moves to READ.
- READ:
  - A read is issued (ce_o=1, we_o=0, addr_o=rd_cnt) when rd_cnt<N and (fifo_count + pending) < 2, or when that sum is 2 and a pop occurs this cycle.
  - pending=1 in the cycle after an issue; q_i is pushed into the FIFO at the end of that cycle.
  - m_valid_o = FIFO not empty; m_data_o = FIFO head. A pop happens on m_valid_o&&m_ready_i.
  - Latency: the first issue happens in the first READ cycle; m_valid_o rises 2 cycles later.
  - With m_ready_i held at 1, one word/cycle is sustained.
  - m_data_o must hold stable while m_valid_o&&!m_ready_i.
  - out_cnt counts pops; the pop with out_cnt==N-1 moves the state to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Counters are AWIDTH+1 bits wide, so N=MEM_SIZE does not wrap. addr_o uses the low AWIDTH bits.
- ce_o=0 whenever no access is issued. No writes occur outside WRITE.
- If s_valid_i is asserted while not in WRITE, it is ignored and nothing is written.

Optional Feature:
- Macro: BRAM_CTRL_REVERSE_RD_EN.
- Defined: the READ phase issues addresses N-1 down to 0, so output order is LIFO. Termination still occurs after N pops.
- Undefined: addresses 0 to N-1, FIFO order. Issue and latency rules are identical in both cases.

Test Plan:
- Basic burst: reset, start with num_cnt_i=2, feed 0x0001 then 0x0002 with m_ready_i=1.
  - BRAM writes addr 1'h00=0x0001 and 0x01=0x0002.
  - m_data_o emits 0x0001 then 0x0002 on consecutive cycles.
  - done_o pulses once; idle_o returns to 1.
- Backpressure: N=4 (data 0xA0..0xA3).
  - Upstream stalls via s_valid_i=0 for 3 cycles mid-burst; m_ready_i toggles 1,0,0,1.
  - Output is exactly 0xA0,0xA1,0xA2,0xA3 with no loss or duplication.
  - m_data_o stays stable during stalls; FIFO never exceeds 2 entries.
- Full depth: N=256, then num_cnt_i=300 (clamped to 256).
  - 256 writes at addr 0x00..0xFF, 256 words out.
  - Throughput of 1/cycle after the 2-cycle latency; no address wrap.
- Zero length: start with num_cnt_i=0.
  - No ce_o activity; done_o pulses 1 cycle after start.
  - start_i asserted during WRITE is ignored.
- Reset mid-READ: assert reset_n=0 after 2 of 4 outputs.
  - All outputs go to 0 and idle_o=1 immediately.
  - A new N=1 burst then completes normally.
- With BRAM_CTRL_REVERSE_RD_EN: N=3 writing 0x11,0x22,0x33.
  - Output order is 0x33,0x22,0x11; done_o after the third pop.
